// File: rtl/way_array_pkg.sv
// Shared types for the multi-way storage array and its flush sweep controller.
package way_array_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } sweep_state_t;

endpackage

// File: rtl/way_bank.sv
// One way of the storage array: data and valid bits per set, one write port,
// one read port with optional same-cycle write forwarding, plus a valid-clear port.
module way_bank #(
   parameter int s_index = 3,
   parameter int width   = 24,
   parameter int bypass  = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               we_i,
   input  logic [s_index-1:0] windex_i,
   input  logic [width-1:0]   datain_i,
   input  logic               clr_i,
   input  logic [s_index-1:0] clrindex_i,
   input  logic [s_index-1:0] rindex_i,
   output logic [width-1:0]   rdata_o,
   output logic               rvalid_o
);

   localparam int num_sets = 2 ** s_index;

   logic [width-1:0]    data_q [num_sets];
   logic [num_sets-1:0] valid_q;
   logic                hit;

   // Write and clear are never requested together: writes are blocked while sweeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < num_sets; i++) begin
            data_q[i] <= '0;
         end
         valid_q <= '0;
      end else begin
         if (we_i) begin
            data_q[windex_i]  <= datain_i;
            valid_q[windex_i] <= 1'b1;
         end else if (clr_i) begin
            valid_q[clrindex_i] <= 1'b0;
         end
      end
   end

   assign hit      = (bypass != 0) && we_i && (rindex_i == windex_i);
   assign rdata_o  = hit ? datain_i : data_q[rindex_i];
   assign rvalid_o = hit ? 1'b1 : valid_q[rindex_i];

endmodule

// File: rtl/way_data_array.sv
// Multi-way cache storage array with per-way writes, per-entry valid bits,
// optional registered read port and a sequential valid-flush sweep.
module way_data_array
   import way_array_pkg::*;
#(
   parameter int s_index = 3,
   parameter int width   = 24,
   parameter int ways    = 2,
   parameter int bypass  = 1,
   parameter int rd_reg  = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   read,
   input  logic [ways-1:0]        load,
   input  logic [s_index-1:0]     rindex,
   input  logic [s_index-1:0]     windex,
   input  logic [width-1:0]       datain,
   input  logic                   flush,
   output logic [ways*width-1:0]  dataout,
   output logic [ways-1:0]        valid_out,
   output logic                   busy
);

   sweep_state_t         state_q;
   logic [s_index-1:0]   ctr_q;
   logic                 busy_q;
   logic [ways*width-1:0] combData;
   logic [ways-1:0]      bankValid;
   logic [ways-1:0]      combValid;

   // Flush sweep: one set per cycle, wrapping the counter back to zero on exit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ctr_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (flush) begin
                  state_q <= SWEEP;
                  ctr_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            SWEEP: begin
               ctr_q <= ctr_q + 1'b1;
               if (ctr_q == '1) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   for (genvar w = 0; w < ways; w++) begin : g_way
      way_bank #(
         .s_index (s_index),
         .width   (width),
         .bypass  (bypass)
      ) u_bank (
         .clk        (clk),
         .rst        (rst),
         .we_i       (load[w] & ~busy_q),
         .windex_i   (windex),
         .datain_i   (datain),
         .clr_i      (busy_q),
         .clrindex_i (ctr_q),
         .rindex_i   (rindex),
         .rdata_o    (combData[w*width +: width]),
         .rvalid_o   (bankValid[w])
      );
   end

   assign combValid = bankValid & ~{ways{busy_q}};
   assign busy      = busy_q;

   if (rd_reg != 0) begin : g_rd_reg
      logic [ways*width-1:0] dataout_q;
      logic [ways-1:0]       validout_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            dataout_q  <= '0;
            validout_q <= '0;
         end else if (read) begin
            dataout_q  <= combData;
            validout_q <= combValid;
         end
      end

      // A value captured before a sweep must not report valid while the sweep runs.
      assign dataout   = dataout_q;
      assign valid_out = validout_q & ~{ways{busy_q}};
   end else begin : g_rd_comb
      logic unusedRead;
      assign unusedRead = read;
      assign dataout    = combData;
      assign valid_out  = combValid;
   end

endmodule

// File: tb/tb_way_data_array.sv
// Scoreboard bench for way_data_array: three configurations share one stimulus
// stream and are compared against an array-level reference model.
module tb_way_data_array;

   localparam int SI   = 3;
   localparam int W    = 24;
   localparam int WAYS = 2;
   localparam int SETS = 8;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                read = 1'b0;
   logic [WAYS-1:0]     load = '0;
   logic [SI-1:0]       rindex = '0;
   logic [SI-1:0]       windex = '0;
   logic [W-1:0]        datain = '0;
   logic                flush = 1'b0;

   logic [WAYS*W-1:0]   doutA, doutB, doutC;
   logic [WAYS-1:0]     voutA, voutB, voutC;
   logic                busyA, busyB, busyC;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [WAYS*W-1:0] dA, dB, dC;
      logic [WAYS-1:0]   vA, vB, vC;
      logic              busy;
      string             tag;
   } exp_t;

   exp_t expQ[$];

   logic [W-1:0]      mData [WAYS][SETS];
   bit                mValid [WAYS][SETS];
   int                sweepLeft;
   logic [WAYS*W-1:0] cData;
   logic [WAYS-1:0]   cValid;

   always #5 clk = ~clk;

   way_data_array #(.s_index(SI), .width(W), .ways(WAYS), .bypass(1), .rd_reg(0)) dutA (
      .clk(clk), .rst(rst), .read(read), .load(load), .rindex(rindex), .windex(windex),
      .datain(datain), .flush(flush), .dataout(doutA), .valid_out(voutA), .busy(busyA));

   way_data_array #(.s_index(SI), .width(W), .ways(WAYS), .bypass(0), .rd_reg(0)) dutB (
      .clk(clk), .rst(rst), .read(read), .load(load), .rindex(rindex), .windex(windex),
      .datain(datain), .flush(flush), .dataout(doutB), .valid_out(voutB), .busy(busyB));

   way_data_array #(.s_index(SI), .width(W), .ways(WAYS), .bypass(1), .rd_reg(1)) dutC (
      .clk(clk), .rst(rst), .read(read), .load(load), .rindex(rindex), .windex(windex),
      .datain(datain), .flush(flush), .dataout(doutC), .valid_out(voutC), .busy(busyC));

   task automatic modelReset();
      for (int w = 0; w < WAYS; w++) begin
         for (int s = 0; s < SETS; s++) begin
            mData[w][s]  = '0;
            mValid[w][s] = 1'b0;
         end
      end
      sweepLeft = 0;
      cData     = '0;
      cValid    = '0;
   endtask

   // One clock cycle: drive inputs, predict outputs for this cycle, then advance the model past the edge.
   task automatic applyStimulus(input bit rstV, input bit readV, input logic [WAYS-1:0] ld,
                                input logic [SI-1:0] ri, input logic [SI-1:0] wi,
                                input logic [W-1:0] din, input bit fl, input string tag);
      exp_t e;
      bit   mBusy;
      bit   hit;
      int   idx;
      @(negedge clk);
      rst = rstV; read = readV; load = ld; rindex = ri; windex = wi; datain = din; flush = fl;
      if (rstV) modelReset();
      mBusy  = (sweepLeft > 0);
      e.tag  = tag;
      e.busy = mBusy;
      for (int w = 0; w < WAYS; w++) begin
         hit = !rstV && ld[w] && !mBusy && (ri == wi);
         e.dB[w*W +: W] = mData[w][ri];
         e.vB[w]        = mBusy ? 1'b0 : mValid[w][ri];
         e.dA[w*W +: W] = hit ? din : mData[w][ri];
         e.vA[w]        = hit ? 1'b1 : e.vB[w];
      end
      e.dC = cData;
      e.vC = mBusy ? '0 : cValid;
      expQ.push_back(e);
      if (!rstV) begin
         if (readV) begin
            cData  = e.dA;
            cValid = e.vA;
         end
         if (mBusy) begin
            idx = SETS - sweepLeft;
            for (int w = 0; w < WAYS; w++) mValid[w][idx] = 1'b0;
            sweepLeft--;
         end else begin
            for (int w = 0; w < WAYS; w++) begin
               if (ld[w]) begin
                  mData[w][wi]  = din;
                  mValid[w][wi] = 1'b1;
               end
            end
            if (fl) sweepLeft = SETS;
         end
      end
   endtask

   task automatic checkOutput(input string name, input logic [WAYS*W-1:0] act, input logic [WAYS*W-1:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // Monitor: one prediction per cycle, compared well after the inputs settle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput({e.tag, " dataA"},  doutA, e.dA);
            checkOutput({e.tag, " validA"}, {{(WAYS*W-WAYS){1'b0}}, voutA}, {{(WAYS*W-WAYS){1'b0}}, e.vA});
            checkOutput({e.tag, " dataB"},  doutB, e.dB);
            checkOutput({e.tag, " validB"}, {{(WAYS*W-WAYS){1'b0}}, voutB}, {{(WAYS*W-WAYS){1'b0}}, e.vB});
            checkOutput({e.tag, " dataC"},  doutC, e.dC);
            checkOutput({e.tag, " validC"}, {{(WAYS*W-WAYS){1'b0}}, voutC}, {{(WAYS*W-WAYS){1'b0}}, e.vC});
            checkOutput({e.tag, " busy"},   {{(WAYS*W-3){1'b0}}, busyA, busyB, busyC},
                        {{(WAYS*W-3){1'b0}}, {3{e.busy}}});
         end
      end
   end

   initial begin
      logic [WAYS-1:0] ld;
      logic [SI-1:0]   ri, wi;
      modelReset();

      applyStimulus(1, 0, 2'b00, 3'd0, 3'd0, 24'h0, 0, "reset");
      applyStimulus(1, 0, 2'b00, 3'd0, 3'd0, 24'h0, 0, "reset");
      for (int i = 0; i < SETS; i++)
         applyStimulus(0, 1, 2'b00, 3'(i), 3'd0, 24'h0, 0, "resetRead");

      applyStimulus(0, 0, 2'b10, 3'd0, 3'd5, 24'hABCDEF, 0, "writeWay1");
      applyStimulus(0, 1, 2'b00, 3'd5, 3'd0, 24'h0, 0, "readIdx5");
      applyStimulus(0, 0, 2'b00, 3'd5, 3'd0, 24'h0, 0, "regLatency");
      applyStimulus(0, 0, 2'b00, 3'd2, 3'd0, 24'h0, 0, "regHold");

      applyStimulus(0, 1, 2'b01, 3'd3, 3'd3, 24'h123456, 0, "bypass");
      applyStimulus(0, 0, 2'b00, 3'd3, 3'd0, 24'h0, 0, "afterBypass");

      for (int i = 0; i < 150; i++) begin
         ld = 2'($urandom_range(0, 3));
         ri = 3'($urandom_range(0, 7));
         wi = ($urandom_range(0, 1) == 1) ? ri : 3'($urandom_range(0, 7));
         applyStimulus(0, 1'($urandom_range(0, 1)), ld, ri, wi, 24'($urandom),
                       ($urandom_range(0, 19) == 0), "random");
      end

      for (int i = 0; i < 10; i++)
         applyStimulus(0, 0, 2'b00, 3'd0, 3'd0, 24'h0, 0, "settle");
      for (int i = 0; i < SETS; i++)
         applyStimulus(0, 1, 2'b11, 3'(i), 3'(i), 24'($urandom), 0, "fill");
      applyStimulus(0, 1, 2'b01, 3'd0, 3'd0, 24'h5A5A5A, 1, "flushWithLoad");
      for (int i = 0; i < SETS; i++)
         applyStimulus(0, 1, 2'($urandom_range(1, 3)), 3'($urandom_range(0, 7)),
                       3'($urandom_range(0, 7)), 24'($urandom), (i == 2), "sweep");
      for (int i = 0; i < SETS; i++)
         applyStimulus(0, 1, 2'b00, 3'(i), 3'd0, 24'h0, 0, "postFlush");

      applyStimulus(0, 0, 2'b11, 3'd4, 3'd4, 24'hC0FFEE, 0, "preReset");
      applyStimulus(0, 1, 2'b00, 3'd4, 3'd0, 24'h0, 1, "flush2");
      for (int i = 0; i < 3; i++)
         applyStimulus(0, 1, 2'b00, 3'd4, 3'd0, 24'h0, 0, "sweep2");
      applyStimulus(1, 0, 2'b00, 3'd4, 3'd0, 24'h0, 0, "midSweepReset");
      applyStimulus(0, 1, 2'b00, 3'd4, 3'd0, 24'h0, 1, "flush3");
      for (int i = 0; i < SETS + 2; i++)
         applyStimulus(0, 1, 2'b00, 3'(i), 3'd0, 24'h0, 0, "sweep3");

      @(negedge clk);
      @(negedge clk);
      #3;
      checks++;
      if (expQ.size() != 0) begin
         failures++;
         $display("[TB] FAIL drain: %0d predictions left, expected 0", expQ.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
